axi_slave_default_resp: RTL
===========================

# axi_slave_default_resp

Parametrised default/error slave for an unused or unmapped `AXI_INF` slave port on the AXI interconnect. Unlike a pure tie-off, it completes every write and read burst with a configurable error response, so a master addressing an unmapped region cannot hang. It also keeps a saturating count of completed error transactions for debug. With `SILENT=1` it degrades to a plain all-zero, never-ready tie-off.

## Interface
Parameters:
- `SILENT`, 0 — 1: every output held 0 permanently; FSMs and counter disabled.
- `RESP_CODE`, 2'b11 — response returned on `WR_BACK_RESP` / `RD_DATA_RESP` (DECERR by default; 2'b10 = SLVERR).
- `RD_FILL`, 32'hDEAD_BEEF — read data pattern, replicated/truncated to the interface data width.
- `ERR_CNT_W`, 16 — width of `err_cnt`.
- ID, address and data widths come from the `AXI_INF` instance; burst length `*_LEN` is 8 bit.

Ports:
- `clk` — input, 1 — sole clock.
- `rstn` — input, 1 — synchronous, active-low reset.
- `AXI_S` — `AXI_INF.S` — slave side. Uses the AW (`WR_ADDR_*`), W (`WR_DATA*`), B (`WR_BACK_*`), AR (`RD_ADDR_*`) and R (`RD_BACK_ID`, `RD_DATA*`) channels.
- `err_cnt` — output, `ERR_CNT_W` — number of completed error transactions, saturating.

## Operation
- Write and read paths are independent FSMs. Each allows one outstanding transaction.
- Write FSM, states `W_IDLE` → `W_DATA` → `W_RESP`:
  - `W_IDLE`: `WR_ADDR_READY`=1. On AW handshake, capture `WR_ADDR_ID` and go to `W_DATA`.
  - `W_DATA`: `WR_DATA_READY`=1. Data and strobes are discarded. A handshake with `WR_DATA_LAST`=1 goes to `W_RESP`. Beat count is not checked against `WR_ADDR_LEN`; `WR_DATA_LAST` is authoritative.
  - `W_RESP`: `WR_BACK_VALID`=1, `WR_BACK_ID`=captured ID, `WR_BACK_RESP`=`RESP_CODE`. On `WR_BACK_READY`, go to `W_IDLE`.
- W beats presented before an AW handshake are not accepted (`WR_DATA_READY`=0 outside `W_DATA`).
- Read FSM, states `R_IDLE` → `R_DATA`:
  - `R_IDLE`: `RD_ADDR_READY`=1. On AR handshake, capture ID, load `beat_cnt`=`RD_ADDR_LEN`, go to `R_DATA`.
  - `R_DATA`: `RD_DATA_VALID`=1, `RD_DATA`=fill, `RD_DATA_RESP`=`RESP_CODE`, `RD_BACK_ID`=captured ID, `RD_DATA_LAST`=(`beat_cnt`==0).
  - Each R handshake decrements `beat_cnt`. The handshake with LAST returns to `R_IDLE`.
  - Beats issued = LEN+1, range 1..256.
- `err_cnt`:
  - +1 per B handshake; +1 per R handshake carrying LAST.
  - Both in the same cycle: +2.
  - Saturates at all-ones; never wraps.
- All outputs are registered or decoded directly from state; no combinational path from any input to any output.

## Timing
- Reset (`rstn`=0 at a `clk` edge): both FSMs go to idle, `beat_cnt`=0, `err_cnt`=0.
- During reset every AXI output is 0. READY outputs become 1 on the first cycle after `rstn` rises.
- Reset mid-burst abandons the transaction; no B or R response is generated for it.
- Write latency:
  - AW handshake at cycle N → `WR_DATA_READY` from N+1.
  - LAST W handshake at cycle M → `WR_BACK_VALID` at M+1.
  - B handshake at cycle K → `WR_ADDR_READY` at K+1.
- Read latency: AR handshake at cycle N → first `RD_DATA_VALID` at N+1. Beats are back-to-back while `RD_DATA_READY`=1.
- Held stable while stalled: `RD_DATA_VALID`, `RD_DATA_LAST`, `RD_BACK_ID` (with `RD_DATA_READY`=0) and `WR_BACK_*` (with `WR_BACK_READY`=0).
- `WR_ADDR_READY` is 0 in `W_DATA` and `W_RESP`. `RD_ADDR_READY` is 0 in `R_DATA`.
- `SILENT=1`: all AXI outputs and `err_cnt` are constant 0 regardless of `rstn`.

## Structure
- Package `axi_default_pkg` holds:
  - `wr_state_t` {`W_IDLE`, `W_DATA`, `W_RESP`};
  - `rd_state_t` {`R_IDLE`, `R_DATA`};
  - constants `AXI_RESP_OKAY`=2'b00, `AXI_RESP_EXOKAY`=2'b01, `AXI_RESP_SLVERR`=2'b10, `AXI_RESP_DECERR`=2'b11.
- Single module, no sub-modules: two `always_ff` FSMs plus the counter. `SILENT` is implemented with a generate branch.

## Test plan
- Single write: AW ID=5 LEN=0, one W beat LAST=1, `WR_BACK_READY`=1 → `WR_BACK_VALID` one cycle after the W handshake, ID=5, RESP=2'b11, `err_cnt`=1.
- Read burst: AR ID=3 LEN=7, `RD_DATA_READY` toggled every cycle → exactly 8 beats. Each beat has DATA=fill, RESP=2'b11, ID=3. LAST only on beat 8. Outputs stable during stalls.
- Backpressure: hold `WR_BACK_READY`=0 for 10 cycles → B outputs constant; `WR_ADDR_READY`=0 throughout; after release, AW accepted on the next cycle.
- Simultaneous completion: B handshake and R LAST handshake in the same cycle → `err_cnt` increments by 2. With `ERR_CNT_W`=2 starting at 3, it stays at 3.
- Reset mid-burst: `rstn`=0 during beat 4 of a LEN=15 read → next cycle all outputs 0. After release, `RD_ADDR_READY`=1, `err_cnt`=0, and no stale beats appear.
- `SILENT`=1: drive full AW/W/AR traffic → every READY/VALID output stays 0 for the whole test.

Source files
------------

// File: rtl/axi_default_pkg.sv
// ---------------------------------------------------------------------------
// axi_default_pkg
// Shared types and constants for the AXI default/error slave.
//   wr_state_t : write-path FSM states (address, data, response)
//   rd_state_t : read-path FSM states (idle, beat streaming)
//   AXI_RESP_* : AXI response encodings
// ---------------------------------------------------------------------------
package axi_default_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_slave_default_resp_if.sv
// ---------------------------------------------------------------------------
// AXI_INF
// Interconnect AXI port bundle.
//   AW : WR_ADDR_{ID,ADDR,LEN,VALID,READY}
//   W  : WR_DATA, WR_DATA_{STRB,LAST,VALID,READY}
//   B  : WR_BACK_{ID,RESP,VALID,READY}
//   AR : RD_ADDR_{ID,ADDR,LEN,VALID,READY}
//   R  : RD_BACK_ID, RD_DATA, RD_DATA_{RESP,LAST,VALID,READY}
// Modport M drives requests, modport S drives responses/readies.
// ---------------------------------------------------------------------------
interface AXI_INF #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     WR_ADDR_ID;
    logic [ADDR_W-1:0]   WR_ADDR;
    logic [7:0]          WR_ADDR_LEN;
    logic                WR_ADDR_VALID;
    logic                WR_ADDR_READY;

    logic [DATA_W-1:0]   WR_DATA;
    logic [DATA_W/8-1:0] WR_DATA_STRB;
    logic                WR_DATA_LAST;
    logic                WR_DATA_VALID;
    logic                WR_DATA_READY;

    logic [ID_W-1:0]     WR_BACK_ID;
    logic [1:0]          WR_BACK_RESP;
    logic                WR_BACK_VALID;
    logic                WR_BACK_READY;

    logic [ID_W-1:0]     RD_ADDR_ID;
    logic [ADDR_W-1:0]   RD_ADDR;
    logic [7:0]          RD_ADDR_LEN;
    logic                RD_ADDR_VALID;
    logic                RD_ADDR_READY;

    logic [ID_W-1:0]     RD_BACK_ID;
    logic [DATA_W-1:0]   RD_DATA;
    logic [1:0]          RD_DATA_RESP;
    logic                RD_DATA_LAST;
    logic                RD_DATA_VALID;
    logic                RD_DATA_READY;

    modport M (
        output WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_VALID,
        input  WR_ADDR_READY,
        output WR_DATA, WR_DATA_STRB, WR_DATA_LAST, WR_DATA_VALID,
        input  WR_DATA_READY,
        input  WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
        output WR_BACK_READY,
        output RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_VALID,
        input  RD_ADDR_READY,
        input  RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
        output RD_DATA_READY
    );

    modport S (
        input  WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_VALID,
        output WR_ADDR_READY,
        input  WR_DATA, WR_DATA_STRB, WR_DATA_LAST, WR_DATA_VALID,
        output WR_DATA_READY,
        output WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
        input  WR_BACK_READY,
        input  RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_VALID,
        output RD_ADDR_READY,
        output RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
        input  RD_DATA_READY
    );

endinterface

// File: rtl/axi_slave_default_resp.sv
// ---------------------------------------------------------------------------
// axi_slave_default_resp
// Default/error slave for an unmapped AXI slave port. Every write burst is
// drained and answered on B with RESP_CODE; every read burst returns LEN+1
// beats of RD_FILL with RESP_CODE. A saturating counter tallies completed
// error transactions. SILENT=1 turns the block into an all-zero tie-off.
// Ports:
//   clk     : sole clock
//   rstn    : synchronous active-low reset
//   AXI_S   : AXI_INF slave modport (AW, W, B, AR, R channels)
//   err_cnt : completed error transactions, saturating at all-ones
// ---------------------------------------------------------------------------
module axi_slave_default_resp
    import axi_default_pkg::*;
#(
    parameter bit          SILENT    = 1'b0,
    parameter logic [1:0]  RESP_CODE = AXI_RESP_DECERR,
    parameter logic [31:0] RD_FILL   = 32'hDEAD_BEEF,
    parameter int          ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    AXI_INF.S                    AXI_S,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int DW = $bits(AXI_S.RD_DATA);
    localparam int IW = $bits(AXI_S.WR_ADDR_ID);

    // RD_FILL repeated across the bus, truncated when the bus is narrower.
    function automatic logic [DW-1:0] fill_word();
        logic [DW-1:0] f;
        for (int i = 0; i < DW; i++) begin
            f[i] = RD_FILL[i % 32];
        end
        return f;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a,
                                                     input logic [1:0]           inc);
        logic [ERR_CNT_W:0] s;
        s = {1'b0, a} + (ERR_CNT_W + 1)'(inc);
        if (s[ERR_CNT_W]) begin
            return '1;
        end
        return s[ERR_CNT_W-1:0];
    endfunction

    if (SILENT) begin : g_silent
        assign AXI_S.WR_ADDR_READY = 1'b0;
        assign AXI_S.WR_DATA_READY = 1'b0;
        assign AXI_S.WR_BACK_VALID = 1'b0;
        assign AXI_S.WR_BACK_ID    = '0;
        assign AXI_S.WR_BACK_RESP  = '0;
        assign AXI_S.RD_ADDR_READY = 1'b0;
        assign AXI_S.RD_DATA_VALID = 1'b0;
        assign AXI_S.RD_DATA_LAST  = 1'b0;
        assign AXI_S.RD_DATA       = '0;
        assign AXI_S.RD_DATA_RESP  = '0;
        assign AXI_S.RD_BACK_ID    = '0;
        assign err_cnt             = '0;
    end else begin : g_active
        wr_state_t              wr_state_q, wr_state_d;
        rd_state_t              rd_state_q, rd_state_d;
        logic [IW-1:0]          wr_id_q;
        logic [IW-1:0]          rd_id_q;
        logic [7:0]             beat_cnt_q;
        logic [ERR_CNT_W-1:0]   err_cnt_q;
        // Holds the address READYs low through reset and for the reset edge
        // itself, so no output ever depends on rstn combinationally.
        logic                   ready_en_q;

        logic aw_hs, w_last_hs, b_hs, ar_hs, r_hs, r_last_hs;

        assign aw_hs     = AXI_S.WR_ADDR_VALID & AXI_S.WR_ADDR_READY;
        assign w_last_hs = AXI_S.WR_DATA_VALID & AXI_S.WR_DATA_READY & AXI_S.WR_DATA_LAST;
        assign b_hs      = AXI_S.WR_BACK_VALID & AXI_S.WR_BACK_READY;
        assign ar_hs     = AXI_S.RD_ADDR_VALID & AXI_S.RD_ADDR_READY;
        assign r_hs      = AXI_S.RD_DATA_VALID & AXI_S.RD_DATA_READY;
        assign r_last_hs = r_hs & AXI_S.RD_DATA_LAST;

        always_comb begin
            wr_state_d = wr_state_q;
            unique case (wr_state_q)
                W_IDLE:  if (aw_hs)     wr_state_d = W_DATA;
                W_DATA:  if (w_last_hs) wr_state_d = W_RESP;
                W_RESP:  if (b_hs)      wr_state_d = W_IDLE;
                default:                wr_state_d = W_IDLE;
            endcase
        end

        always_comb begin
            rd_state_d = rd_state_q;
            unique case (rd_state_q)
                R_IDLE:  if (ar_hs)     rd_state_d = R_DATA;
                R_DATA:  if (r_last_hs) rd_state_d = R_IDLE;
                default:                rd_state_d = R_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                wr_state_q <= W_IDLE;
                rd_state_q <= R_IDLE;
                beat_cnt_q <= '0;
                err_cnt_q  <= '0;
                ready_en_q <= 1'b0;
            end else begin
                wr_state_q <= wr_state_d;
                rd_state_q <= rd_state_d;
                ready_en_q <= 1'b1;
                if (ar_hs) begin
                    beat_cnt_q <= AXI_S.RD_ADDR_LEN;
                end else if (r_hs && !r_last_hs) begin
                    beat_cnt_q <= beat_cnt_q - 8'd1;
                end
                err_cnt_q <= sat_add(err_cnt_q, {1'b0, b_hs} + {1'b0, r_last_hs});
            end
        end

        // IDs are only observable while the matching response is valid.
        always_ff @(posedge clk) begin
            if (aw_hs) wr_id_q <= AXI_S.WR_ADDR_ID;
            if (ar_hs) rd_id_q <= AXI_S.RD_ADDR_ID;
        end

        // Data-type outputs are forced to zero outside their valid state so
        // that reset drives every output to zero.
        assign AXI_S.WR_ADDR_READY = ready_en_q && (wr_state_q == W_IDLE);
        assign AXI_S.WR_DATA_READY = (wr_state_q == W_DATA);
        assign AXI_S.WR_BACK_VALID = (wr_state_q == W_RESP);
        assign AXI_S.WR_BACK_ID    = (wr_state_q == W_RESP) ? wr_id_q : '0;
        assign AXI_S.WR_BACK_RESP  = (wr_state_q == W_RESP) ? RESP_CODE : 2'b00;
        assign AXI_S.RD_ADDR_READY = ready_en_q && (rd_state_q == R_IDLE);
        assign AXI_S.RD_DATA_VALID = (rd_state_q == R_DATA);
        assign AXI_S.RD_DATA_LAST  = (rd_state_q == R_DATA) && (beat_cnt_q == 8'd0);
        assign AXI_S.RD_DATA       = (rd_state_q == R_DATA) ? fill_word() : '0;
        assign AXI_S.RD_DATA_RESP  = (rd_state_q == R_DATA) ? RESP_CODE : 2'b00;
        assign AXI_S.RD_BACK_ID    = (rd_state_q == R_DATA) ? rd_id_q : '0;
        assign err_cnt             = err_cnt_q;
    end

endmodule
